// File: rtl/uart_rx_ovs_if.sv
// Output-side bundle of the oversampling UART receiver: received word,
// status flags and the valid/ready handshake toward the byte consumer.
interface uart_rx_ovs_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ovs.sv
// Parametrised oversampling UART receiver with 3-sample majority voting,
// false-start rejection, parity/framing/break/overrun status and valid/ready output.
module uart_rx_ovs #(
    parameter int    DATA_BITS = 8,
    parameter int    OVS       = 16,
    parameter string PARITY    = "NONE",
    parameter int    STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          os_tick,
    input  logic          rxd,
    uart_rx_ovs_if.master rx_if
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);
    localparam bit PAR_ODD = (PARITY == "ODD");
    localparam bit PAR_EN  = PAR_ODD || (PARITY == "EVEN");

    localparam logic [TW-1:0] T_S0   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVS / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic                 rxd_meta, rxd_sync;
    logic                 armed;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 smp0, smp1;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err_q, frm_err_q, any_one;

    logic                 majority, decide, bit_end, parity_exp;
    logic                 start_frame, complete;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_q, ferr_q, brk_q, ovr_q;

    assign majority   = (smp0 & smp1) | (smp0 & rxd_sync) | (smp1 & rxd_sync);
    assign decide     = os_tick && (tick_cnt == T_DEC);
    assign bit_end    = os_tick && (tick_cnt == T_LAST);
    assign parity_exp = (^shift_reg) ^ PAR_ODD;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        complete    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (os_tick && armed && !rxd_sync) begin
                    state_d     = S_START;
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (decide && majority)  state_d = S_IDLE;
                else if (bit_end)        state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_cnt == LAST_BIT) state_d = PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Completion on the last stop decision, not the bit end, to leave resync margin.
                if (decide && stop_cnt == STOP_LAST) begin
                    state_d  = S_IDLE;
                    complete = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta  <= 1'b1;
            rxd_sync  <= 1'b1;
            state_q   <= S_IDLE;
            armed     <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            smp0      <= 1'b1;
            smp1      <= 1'b1;
            shift_reg <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            any_one   <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            state_q  <= state_d;
            if (os_tick) begin
                tick_cnt <= (state_q == S_IDLE || tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
                if (tick_cnt == T_S0) smp0 <= rxd_sync;
                if (tick_cnt == T_S1) smp1 <= rxd_sync;

                if (state_q == S_IDLE) begin
                    if (rxd_sync) armed <= 1'b1;
                    if (start_frame) begin
                        armed     <= 1'b0;
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        par_err_q <= 1'b0;
                        frm_err_q <= 1'b0;
                        any_one   <= 1'b0;
                    end
                end

                if (tick_cnt == T_DEC) begin
                    case (state_q)
                        S_DATA: begin
                            shift_reg[bit_cnt] <= majority;
                            any_one            <= any_one | majority;
                        end
                        S_PARITY: begin
                            if (majority != parity_exp) par_err_q <= 1'b1;
                            any_one <= any_one | majority;
                        end
                        S_STOP: begin
                            if (!majority) frm_err_q <= 1'b1;
                            any_one <= any_one | majority;
                        end
                        default: ;
                    endcase
                end

                if (tick_cnt == T_LAST) begin
                    if (state_q == S_DATA) bit_cnt  <= bit_cnt + BW'(1);
                    if (state_q == S_STOP) stop_cnt <= 1'b1;
                end
            end
        end
    end

    // Output register: load on completion unless an unaccepted word is still held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || rx_if.rx_ready) begin
                    data_q  <= shift_reg;
                    perr_q  <= par_err_q;
                    ferr_q  <= frm_err_q | ~majority;
                    brk_q   <= ~(any_one | majority);
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.break_det  = brk_q;
    assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs (8 data bits, 16x, even parity, 1 stop): line levels are
// built per oversampling tick, received words are compared with a frame-level model.
module tb_uart_rx_ovs;
    localparam int DB  = 8;
    localparam int OVS = 16;

    typedef struct {
        logic [7:0] data;
        bit         pe, fe, bk;
    } word_t;

    typedef struct {
        logic [7:0] data;
        bit         pbit, stop;
        logic [7:0] exp_data;
        bit         exp_pe, exp_fe, exp_bk;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, os_tick = 1'b0, rxd = 1'b1;
    int   div = 0;
    int   checks = 0, failures = 0;
    int   ovr_cnt = 0, valid_cycles = 0;
    word_t got_q[$];
    bit    lv[$];
    vec_t  vecs[8];

    uart_rx_ovs_if #(.DATA_BITS(DB)) bus ();

    uart_rx_ovs #(
        .DATA_BITS(DB), .OVS(OVS), .PARITY("EVEN"), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rxd(rxd), .rx_if(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div     = (div == 3) ? 0 : div + 1;
        os_tick = (div == 0);
    end

    always @(negedge clk) begin
        if (bus.overrun) ovr_cnt++;
        if (bus.rx_valid) valid_cycles++;
        if (bus.rx_valid && bus.rx_ready)
            got_q.push_back('{bus.rx_data, bus.parity_err, bus.frame_err, bus.break_det});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        int g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (!os_tick && g < 50);
        #1;
    endtask

    task automatic add(input bit v, input int n);
        repeat (n) lv.push_back(v);
    endtask

    task automatic build(input logic [7:0] d, input bit p, input bit s, input int idle_bits);
        add(1'b0, OVS);
        for (int i = 0; i < DB; i++) add(d[i], OVS);
        add(p, OVS);
        add(s, OVS);
        add(1'b1, idle_bits * OVS);
    endtask

    task automatic play();
        foreach (lv[i]) begin
            rxd = lv[i];
            tick();
        end
        lv.delete();
    endtask

    // Frame-level reference: what the receiver must report for one transmitted frame.
    function automatic word_t model(input logic [7:0] d, input bit p, input bit s);
        word_t w;
        w.data = d;
        w.pe   = (p != (^d));
        w.fe   = !s;
        w.bk   = (d == 8'h00) && !p && !s;
        return w;
    endfunction

    task automatic expect_word(input string name, input word_t e);
        word_t w;
        check({name, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            check({name, "_data"}, w.data, e.data);
            check({name, "_perr"}, w.pe, e.pe);
            check({name, "_ferr"}, w.fe, e.fe);
            check({name, "_brk"},  w.bk, e.bk);
        end
        got_q.delete();
    endtask

    initial begin
        word_t e;
        logic [7:0] d;
        bit p, s;
        int ob;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};

        bus.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_valid", bus.rx_valid, 0);
        check("reset_data", bus.rx_data, 0);
        check("reset_flags", {bus.parity_err, bus.frame_err, bus.break_det, bus.overrun}, 0);
        rst = 1'b0;
        add(1'b1, 2 * OVS);
        play();

        foreach (vecs[i]) begin
            valid_cycles = 0;
            build(vecs[i].data, vecs[i].pbit, vecs[i].stop, 2);
            play();
            if (i == 0) check("valid_one_cycle", valid_cycles, 1);
            e = '{vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_bk};
            expect_word($sformatf("vec%0d", i), e);
        end

        // Short low pulse on an idle line is a false start.
        add(1'b0, 4);
        add(1'b1, 3 * OVS);
        play();
        check("false_start_none", got_q.size(), 0);

        // One-tick glitch at the middle sample of data bit 0 is outvoted.
        build(8'h01, 1'b1, 1'b1, 2);
        lv[OVS + OVS / 2] = 1'b0;
        play();
        expect_word("glitch", model(8'h01, 1'b1, 1'b1));

        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom);
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 3) != 0);
            build(d, p, s, $urandom_range(1, 3));
            play();
            expect_word($sformatf("rand%0d", n), model(d, p, s));
        end

        // Overrun: consumer stalled across two frames.
        bus.rx_ready = 1'b0;
        build(8'h11, 1'b0, 1'b1, 2);
        play();
        check("hold_valid", bus.rx_valid, 1);
        check("hold_none_taken", got_q.size(), 0);
        ob = ovr_cnt;
        build(8'h22, 1'b0, 1'b1, 2);
        play();
        check("overrun_pulses", ovr_cnt - ob, 1);
        check("hold_data", bus.rx_data, 8'h11);
        bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        expect_word("after_overrun", model(8'h11, 1'b0, 1'b1));
        check("valid_cleared", bus.rx_valid, 0);

        // Break: line low for 12 bit times, then high again.
        add(1'b0, 12 * OVS);
        play();
        expect_word("break", model(8'h00, 1'b0, 1'b0));
        add(1'b1, 2 * OVS);
        play();
        check("break_single", got_q.size(), 0);
        build(8'h7E, 1'b0, 1'b1, 2);
        play();
        expect_word("post_break", model(8'h7E, 1'b0, 1'b1));

        // Reset mid-frame.
        build(8'h55, 1'b0, 1'b1, 0);
        for (int i = 0; i < 5 * OVS; i++) begin
            rxd = lv[i];
            tick();
        end
        lv.delete();
        rst = 1'b1;
        #2;
        check("midrst_valid", bus.rx_valid, 0);
        check("midrst_data", bus.rx_data, 0);
        check("midrst_flags", {bus.parity_err, bus.frame_err, bus.break_det, bus.overrun}, 0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        add(1'b1, 2 * OVS);
        build(8'h3C, 1'b0, 1'b1, 2);
        play();
        expect_word("post_reset", model(8'h3C, 1'b0, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
